// File: rtl/cond_arbiter.sv
// Two-requester burst arbiter driving a shared counter enable (cond_o) and pulse counter.
// Define COND_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round robin.
`timescale 1ns/1ps
module cond_arbiter #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [1:0]       req_i,
  input  logic [LEN_W-1:0] len0_i,
  input  logic [LEN_W-1:0] len1_i,
  input  logic             abort_i,
  output logic [1:0]       gnt_o,
  output logic             cond_o,
  output logic             busy_o,
  output logic [1:0]       done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             state_dbg_o
);

  // valid/ready: none; req_i is a level request, observed only while IDLE,
  // and the burst owner is told it finished by a single done_o pulse.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LEN_W-1:0] REM_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] count_q;
  logic             win;
  logic             grant;
  logic [1:0]       owner_oh;

`ifdef COND_ARB_FIXED_PRIO_EN
  always_comb begin
    win = 1'b0;
    if (req_i == 2'b10) win = 1'b1;
  end
`else
  logic last_q;

  always_comb begin
    win = 1'b0;
    case (req_i)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  // Reset value 1 gives requester 0 first priority on a tie.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)  last_q <= 1'b1;
    else if (grant) last_q <= win;
  end
`endif

  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    grant   = 1'b0;
    gnt_o   = 2'b00;
    cond_o  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 2'b00;
    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          grant   = 1'b1;
          state_d = RUN;
          owner_d = win;
          rem_d   = win ? len1_i : len0_i;
        end
      end
      RUN: begin
        gnt_o  = owner_oh;
        busy_o = 1'b1;
        if (rem_q != '0) begin
          cond_o = 1'b1;
          // Abort zeroes rem so the done cycle still follows.
          rem_d  = abort_i ? '0 : rem_q - REM_ONE;
        end else begin
          done_o  = owner_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      owner_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      if (cond_o) count_q <= count_q + CNT_ONE;
    end
  end

  assign count_o     = count_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_cond_arbiter.sv
// Randomized bench for cond_arbiter against a burst-schedule reference model.
// Build with COND_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
`timescale 1ns/1ps
module tb_cond_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic [1:0] req_i = 2'b00;
  logic [3:0] len0_i = 4'd0;
  logic [3:0] len1_i = 4'd0;
  logic       abort_i = 1'b0;
  logic [1:0] gnt_o;
  logic       cond_o;
  logic       busy_o;
  logic [1:0] done_o;
  logic [7:0] count_o;
  logic       state_dbg_o;

  cond_arbiter #(.LEN_W(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_i(req_i), .len0_i(len0_i),
    .len1_i(len1_i), .abort_i(abort_i), .gnt_o(gnt_o), .cond_o(cond_o),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .state_dbg_o(state_dbg_o)
  );

  always #5 clk_i = ~clk_i;

  // Each queued entry is the expected output of one future RUN cycle.
  typedef struct packed {
    logic [1:0] gnt;
    logic       cond;
    logic       done;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] exp_cnt;
  logic       last_win;
  int         total = 0;
  int         bad = 0;
  int         grants_seen[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    ent_t e;
    e = '0;
    if (exp_q.size() != 0) e = exp_q[0];
    check({tag, "_gnt"},   32'(gnt_o),  32'(e.gnt));
    check({tag, "_cond"},  32'(cond_o), 32'(e.cond));
    check({tag, "_done"},  32'(done_o), e.done ? 32'(e.gnt) : 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'(exp_q.size() != 0));
    check({tag, "_state"}, 32'(state_dbg_o), 32'(exp_q.size() != 0));
    check({tag, "_cnt"},   32'(count_o), 32'(exp_cnt));
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic model_step();
    ent_t cur, fin;
    int   w;
    int   l;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      if (cur.cond) begin
        exp_cnt = exp_cnt + 8'd1;
        if (abort_i) begin
          fin = exp_q[$];
          exp_q.delete();
          exp_q.push_back(fin);
        end
      end
    end else if (req_i != 2'b00) begin
      if (req_i == 2'b01) w = 0;
      else if (req_i == 2'b10) w = 1;
`ifdef COND_ARB_FIXED_PRIO_EN
      else w = 0;
`else
      else w = last_win ? 0 : 1;
      last_win = (w == 1);
`endif
      grants_seen.push_back(w);
      l = (w == 1) ? int'(len1_i) : int'(len0_i);
      for (int i = 0; i < l; i++) exp_q.push_back('{gnt: (w == 1) ? 2'b10 : 2'b01, cond: 1'b1, done: 1'b0});
      exp_q.push_back('{gnt: (w == 1) ? 2'b10 : 2'b01, cond: 1'b0, done: 1'b1});
    end
  endtask

  task automatic do_cycle(input string tag, input logic [1:0] r, input logic [3:0] l0,
                          input logic [3:0] l1, input logic ab);
    @(negedge clk_i);
    check_outputs(tag);
    req_i = r; len0_i = l0; len1_i = l1; abort_i = ab;
    model_step();
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic apply_reset(input string tag);
    @(negedge clk_i);
    check_outputs({tag, "_pre"});
    #2 reset_ni = 1'b0;
    #1;
    check({tag, "_rst_gnt"},  32'(gnt_o),   32'd0);
    check({tag, "_rst_cond"}, 32'(cond_o),  32'd0);
    check({tag, "_rst_busy"}, 32'(busy_o),  32'd0);
    check({tag, "_rst_done"}, 32'(done_o),  32'd0);
    check({tag, "_rst_cnt"},  32'(count_o), 32'd0);
    exp_q.delete();
    grants_seen.delete();
    exp_cnt  = 8'd0;
    last_win = 1'b1;
    req_i = 2'b00; abort_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, "_rst_hold_done"}, 32'(done_o), 32'd0);
    reset_ni = 1'b1;
  endtask

  logic [1:0] r;

  initial begin
    exp_cnt  = 8'd0;
    last_win = 1'b1;
    #12 reset_ni = 1'b1;

    // Single requester 0, length 3.
    apply_reset("r34");
    do_cycle("r34", 2'b01, 4'd3, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) do_cycle("r34", 2'b00, 4'd0, 4'd0, 1'b0);
    check("r34_count", 32'(count_o), 32'd3);

    // Both requesting: order alternates (or stays on 0 with fixed priority).
    apply_reset("r35");
    for (int i = 0; i < 16; i++) do_cycle("r35", 2'b11, 4'd2, 4'd1, 1'b0);
    for (int i = 0; i < grants_seen.size() && i < 4; i++) begin
`ifdef COND_ARB_FIXED_PRIO_EN
      check("r35_order", 32'(grants_seen[i]), 32'd0);
`else
      check("r35_order", 32'(grants_seen[i]), 32'(i % 2));
`endif
    end

    // Zero-length burst from requester 1.
    apply_reset("r36");
    do_cycle("r36", 2'b10, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle("r36", 2'b00, 4'd0, 4'd0, 1'b0);
    check("r36_count", 32'(count_o), 32'd0);

    // Abort in the second cond cycle of a length-15 burst.
    apply_reset("r37");
    do_cycle("r37", 2'b01, 4'd15, 4'd0, 1'b0);
    do_cycle("r37", 2'b00, 4'd0, 4'd0, 1'b0);
    do_cycle("r37", 2'b00, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) do_cycle("r37", 2'b00, 4'd0, 4'd0, 1'b1);
    check("r37_count", 32'(count_o), 32'd2);

    // Reset in the middle of a length-5 burst.
    apply_reset("r39");
    do_cycle("r39", 2'b01, 4'd5, 4'd0, 1'b0);
    do_cycle("r39", 2'b00, 4'd0, 4'd0, 1'b0);
    do_cycle("r39", 2'b00, 4'd0, 4'd0, 1'b0);
    apply_reset("r39b");
    for (int i = 0; i < 4; i++) do_cycle("r39c", 2'b00, 4'd0, 4'd0, 1'b0);

    // Random traffic, long enough for count_o to wrap several times.
    apply_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      r = 2'($urandom_range(0, 3));
      do_cycle("rnd", r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 499) == 0) apply_reset("rnd_mid");
    end
    do_cycle("end", 2'b00, 4'd0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
